// File: rtl/vecaris_pkg.sv
// vecaris_pkg: shared clear-FSM encoding and default register-file parameters
package vecaris_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam bit DEF_ZERO_R0 = 1'b0;
  localparam bit DEF_BYPASS = 1'b0;
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_e;
endpackage

// File: rtl/reg_clr_seq.sv
// reg_clr_seq: sweep-clear sequencer stepping an index over every entry once per request
// ports: clk, rst_n (async, active-low), clr_req in; clr_busy, sweep_idx, sweep_en out
module reg_clr_seq import vecaris_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] sweep_idx,
  output logic              sweep_en
);
  clr_state_e state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state == CLR_SWEEP) ? cnt + 1'b1 : '0;
    end
  end
  // the counter wraps to zero on the last entry, so it is already loaded for the next sweep
  always_comb begin
    state_nxt = state;
    state_nxt = (state == CLR_IDLE) ? (clr_req ? CLR_SWEEP : CLR_IDLE) : (&cnt ? CLR_IDLE : CLR_SWEEP);
  end
  assign clr_busy = (state == CLR_SWEEP);
  assign sweep_en = clr_busy;
  assign sweep_idx = cnt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with per-entry pending scoreboard and sweep clear
// ports: clk, rst_n (async, active-low); write reg_wr_en/addr/data; reads reg_rd_addr_1/2 ->
//        reg_rd_data_1/2 and rd_pend_1/2; reserve rsv_en/rsv_addr; clear clr_req -> clr_busy
module reg_file_sb import vecaris_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit ZERO_R0 = DEF_ZERO_R0,
  parameter bit BYPASS  = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_wr_addr,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic [ADDR_W-1:0] reg_rd_addr_1,
  output logic [DATA_W-1:0] reg_rd_data_1,
  input  logic [ADDR_W-1:0] reg_rd_addr_2,
  output logic [DATA_W-1:0] reg_rd_data_2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rd_pend_1,
  output logic              rd_pend_2,
  input  logic              clr_req,
  output logic              clr_busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [ADDR_W-1:0] sweep_idx;
  logic              sweep_en, wr_ok, rsv_ok, byp_1, byp_2;
  reg_clr_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .clr_busy(clr_busy), .sweep_idx(sweep_idx), .sweep_en(sweep_en)
  );
  assign wr_ok = reg_wr_en && !clr_busy && !(ZERO_R0 && reg_wr_addr == '0);
  assign rsv_ok = rsv_en && !(ZERO_R0 && rsv_addr == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // the swept entry ends cleared even if reserved in the same cycle; otherwise reserve beats write
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_en && sweep_idx == ADDR_W'(i)) begin
          mem[i] <= '0;
          pend[i] <= 1'b0;
        end else begin
          if (wr_ok && reg_wr_addr == ADDR_W'(i)) mem[i] <= reg_wr_data;
          pend[i] <= (rsv_ok && rsv_addr == ADDR_W'(i)) ? 1'b1 : (wr_ok && reg_wr_addr == ADDR_W'(i)) ? 1'b0 : pend[i];
        end
      end
    end
  end
  // wr_ok already excludes clr_busy, so no forwarding happens during a sweep
  assign byp_1 = BYPASS && rst_n && wr_ok && reg_wr_addr == reg_rd_addr_1;
  assign byp_2 = BYPASS && rst_n && wr_ok && reg_wr_addr == reg_rd_addr_2;
  assign reg_rd_data_1 = (ZERO_R0 && reg_rd_addr_1 == '0) ? '0 : byp_1 ? reg_wr_data : mem[reg_rd_addr_1];
  assign reg_rd_data_2 = (ZERO_R0 && reg_rd_addr_2 == '0) ? '0 : byp_2 ? reg_wr_data : mem[reg_rd_addr_2];
  assign rd_pend_1 = pend[reg_rd_addr_1];
  assign rd_pend_2 = pend[reg_rd_addr_2];
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench driving a default instance and a BYPASS=1/ZERO_R0=1 instance in parallel
module tb_reg_file_sb;
  logic clk = 0, rst_n = 0;
  logic wr_en = 0, rsv_en = 0, clr_req = 0;
  logic [3:0] wr_addr = 0, rd_addr_1 = 0, rd_addr_2 = 0, rsv_addr = 0;
  logic [15:0] wr_data = 0;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic a_p1, a_p2, a_busy, b_p1, b_p2, b_busy;
  int checks = 0, failures = 0;
  typedef struct {int id; logic [15:0] val; string nm;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  reg_file_sb dut_a (
    .clk(clk), .rst_n(rst_n), .reg_wr_en(wr_en), .reg_wr_addr(wr_addr), .reg_wr_data(wr_data),
    .reg_rd_addr_1(rd_addr_1), .reg_rd_data_1(a_rd1), .reg_rd_addr_2(rd_addr_2), .reg_rd_data_2(a_rd2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend_1(a_p1), .rd_pend_2(a_p2),
    .clr_req(clr_req), .clr_busy(a_busy)
  );
  reg_file_sb #(.ZERO_R0(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .reg_wr_en(wr_en), .reg_wr_addr(wr_addr), .reg_wr_data(wr_data),
    .reg_rd_addr_1(rd_addr_1), .reg_rd_data_1(b_rd1), .reg_rd_addr_2(rd_addr_2), .reg_rd_data_2(b_rd2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pend_1(b_p1), .rd_pend_2(b_p2),
    .clr_req(clr_req), .clr_busy(b_busy)
  );
  // ids: 0 a_rd1, 1 a_rd2, 2 a_pend1, 3 a_pend2, 4 a_busy, 5 b_rd1, 6 b_pend1, 7 b_busy
  function automatic logic [15:0] obs(input int id);
    case (id)
      0: obs = a_rd1;
      1: obs = a_rd2;
      2: obs = {15'd0, a_p1};
      3: obs = {15'd0, a_p2};
      4: obs = {15'd0, a_busy};
      5: obs = b_rd1;
      6: obs = {15'd0, b_p1};
      default: obs = {15'd0, b_busy};
    endcase
  endfunction
  task automatic expect_v(input int id, input logic [15:0] v, input string nm);
    q.push_back('{id, v, nm});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = 0;
    rsv_en = 0;
    clr_req = 0;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (obs(e.id) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", e.nm, obs(e.id), e.val, $time);
      end
    end
  end
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      step();
      wr_en = 1; wr_addr = 4'(i); wr_data = v;
    end
  endtask
  initial begin
    step();
    expect_v(0, 16'h0, "reset_rd1"); expect_v(1, 16'h0, "reset_rd2");
    expect_v(2, 16'h0, "reset_pend1"); expect_v(4, 16'h0, "reset_busy_a"); expect_v(7, 16'h0, "reset_busy_b");
    step();
    rst_n = 1;
    step();
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234; rd_addr_1 = 3; rd_addr_2 = 4;
    expect_v(0, 16'h0, "nobyp_same_cycle"); expect_v(5, 16'h1234, "byp_same_cycle");
    step();
    idle();
    expect_v(0, 16'h1234, "rd1_addr3"); expect_v(1, 16'h0, "rd2_addr4"); expect_v(5, 16'h1234, "b_rd1_addr3");
    step();
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; rd_addr_1 = 5;
    expect_v(0, 16'h0, "nobyp_beef"); expect_v(5, 16'hBEEF, "byp_beef");
    step();
    idle();
    expect_v(0, 16'hBEEF, "rd_beef_a"); expect_v(5, 16'hBEEF, "rd_beef_b");
    step();
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; rsv_en = 1; rsv_addr = 0; rd_addr_1 = 0;
    expect_v(5, 16'h0, "r0_byp_zero");
    step();
    idle();
    expect_v(0, 16'hFFFF, "r0_a_written"); expect_v(2, 16'h1, "r0_a_pend");
    expect_v(5, 16'h0, "r0_b_zero"); expect_v(6, 16'h0, "r0_b_pend");
    step();
    rsv_en = 1; rsv_addr = 7; rd_addr_1 = 7;
    expect_v(2, 16'h0, "pend_no_fwd");
    step();
    idle();
    expect_v(2, 16'h1, "pend_after_rsv");
    step();
    wr_en = 1; wr_addr = 7; wr_data = 16'h0007;
    expect_v(2, 16'h1, "pend_during_wr");
    step();
    idle();
    expect_v(2, 16'h0, "pend_after_wr"); expect_v(0, 16'h0007, "rd_after_wr7");
    step();
    rsv_en = 1; rsv_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 16'h0077;
    expect_v(2, 16'h0, "pend_same_pre");
    step();
    rsv_addr = 8; wr_data = 16'h0078; rd_addr_2 = 8;
    expect_v(2, 16'h1, "rsv_wins"); expect_v(0, 16'h0077, "rd_0077");
    step();
    idle();
    expect_v(2, 16'h0, "diff_wr_clears"); expect_v(0, 16'h0078, "rd_0078"); expect_v(3, 16'h1, "diff_rsv_sets");
    fill(16'hA5A5);
    step();
    idle();
    clr_req = 1;
    expect_v(4, 16'h0, "busy_pre_sweep");
    for (int k = 0; k < 16; k++) begin
      step();
      idle();
      clr_req = (k == 5);
      wr_en = (k == 3); wr_addr = 2; wr_data = 16'h1111; rd_addr_1 = 2; rd_addr_2 = 9;
      expect_v(4, 16'h1, "busy_a"); expect_v(7, 16'h1, "busy_b");
      if (k == 3) expect_v(5, 16'h0, "no_byp_in_sweep");
      if (k == 4) begin
        expect_v(0, 16'h0, "swept_reads_0"); expect_v(1, 16'hA5A5, "unswept_keeps");
      end
    end
    step();
    idle();
    rd_addr_2 = 8;
    expect_v(4, 16'h0, "busy_end_a"); expect_v(7, 16'h0, "busy_end_b"); expect_v(3, 16'h0, "pend_swept");
    for (int i = 0; i < 16; i++) begin
      step();
      rd_addr_1 = 4'(i);
      expect_v(0, 16'h0, "cleared_entry");
    end
    fill(16'hA5A5);
    step();
    idle();
    clr_req = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      clr_req = 0; rd_addr_1 = 9; rd_addr_2 = 15;
      expect_v(4, 16'h1, "busy_before_rst");
      if (k == 4) expect_v(1, 16'hA5A5, "pre_rst_data");
    end
    step();
    rst_n = 0;
    expect_v(4, 16'h0, "rst_busy_a"); expect_v(7, 16'h0, "rst_busy_b");
    expect_v(0, 16'h0, "rst_rd1"); expect_v(1, 16'h0, "rst_rd2");
    step();
    rst_n = 1;
    clr_req = 1;
    expect_v(4, 16'h0, "post_rst_idle");
    for (int k = 0; k < 16; k++) begin
      step();
      clr_req = 0;
      expect_v(4, 16'h1, "resweep_busy");
    end
    step();
    expect_v(4, 16'h0, "resweep_done");
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
